// File: rtl/if_inst_queue_pkg.sv
// Shared definitions for the IF instruction queue: exception code width,
// NOP encoding, legal DEPTH range and the layout of one queue entry.
package if_inst_queue_pkg;

    localparam int          EXCCODE_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          DEPTH_MIN = 2;
    localparam int          DEPTH_MAX = 16;

    // One queue entry; pc, instr, exception and exccode always move together.
    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic                 exception;
        logic [EXCCODE_W-1:0] exccode;
    } if_entry_t;

    localparam int ENTRY_W = $bits(if_entry_t);

    // Bit position of the exception flag inside a packed entry.
    localparam int EXC_BIT = EXCCODE_W;

endpackage

// File: rtl/if_queue_ram.sv
// Entry storage for the IF instruction queue: DEPTH x ENTRY_W register
// array, one synchronous write port and one asynchronous read port.
module if_queue_ram
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [ENTRY_W-1:0]       i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [ENTRY_W-1:0]       o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    // Write one entry per cycle; reset clears only the exception flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: pc/instr payload is deliberately left unreset; the queue
            // masks every output while it is empty, so stale data never leaks.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i][EXC_BIT] <= 1'b0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_inst_queue.sv
// IF-to-ID instruction queue: buffers fetched instructions with their PC
// and fetch exception status, presenting the oldest entry to decode.
// Minimum latency is one cycle; there is no bypass from input to output.
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    input  logic                   in_exception,
    input  logic [EXCCODE_W-1:0]   in_exccode,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic                   out_exception,
    output logic [EXCCODE_W-1:0]   out_exccode,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("if_inst_queue: DEPTH must be a power of two between 2 and 16");
    end

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_we;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    if_entry_t          w_head;

    // Handshake depends only on the registered count, never on out_ready,
    // so a full queue refuses a push even when decode drains it this cycle.
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    // A flush discards a same-cycle push, so the write is suppressed as well.
    assign w_we    = w_push && !flush;
    assign w_wdata = {in_pc, in_instr, in_exception, in_exccode};

    if_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign w_head = if_entry_t'(w_rdata);

    // Pointer and occupancy update: reset, then flush, then push/pop.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits, so the increment wraps to 0.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Present the head entry, forced to a zero NOP while the queue is empty.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        out_pc        = '0;
        out_instr     = NOP_INSTR;
        out_exception = 1'b0;
        out_exccode   = '0;
        if (out_valid) begin
            out_pc        = w_head.pc;
            out_instr     = w_head.instr;
            out_exception = w_head.exception;
            out_exccode   = w_head.exccode;
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// Self-checking bench for if_inst_queue (DEPTH=4): a table of directed
// vectors, hand-written corner sequences and a randomized run, all checked
// against a queue-based reference model kept in the bench.
module tb_if_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_exception;
    logic [4:0]  in_exccode;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exception;
    logic [4:0]  out_exccode;
    logic        out_ready;
    logic [2:0]  count;

    always #5 clk = ~clk;

    if_inst_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .in_exception  (in_exception),
        .in_exccode    (in_exccode),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_exception (out_exception),
        .out_exccode   (out_exccode),
        .out_ready     (out_ready),
        .count         (count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [4:0]  code;
    } ent_t;

    ent_t model_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the
    // rising edge, then leave the caller 1 time unit after the edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic e, input logic [4:0] c, input logic ordy);
        bit do_push;
        bit do_pop;
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins;
        in_exception = e; in_exccode = c; out_ready = ordy;
        @(posedge clk);
        if (!r || f) begin
            model_q.delete();
        end else begin
            do_push = iv && (model_q.size() < DEPTH);
            do_pop  = ordy && (model_q.size() != 0);
            if (do_pop)  model_q.delete(0);
            if (do_push) model_q.push_back('{pc, ins, e, c});
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        ent_t head;
        head = '{32'h0, 32'h0, 1'b0, 5'h0};
        if (model_q.size() != 0) head = model_q[0];
        check({tag, " count"},     32'(count),         32'(model_q.size()));
        check({tag, " in_ready"},  32'(in_ready),      32'(model_q.size() < DEPTH));
        check({tag, " out_valid"}, 32'(out_valid),     32'(model_q.size() != 0));
        check({tag, " out_pc"},    out_pc,             head.pc);
        check({tag, " out_instr"}, out_instr,          head.instr);
        check({tag, " out_exc"},   32'(out_exception), 32'(head.exc));
        check({tag, " out_code"},  32'(out_exccode),   32'(head.code));
    endtask

    typedef struct {
        logic        r, f, iv;
        logic [31:0] pc, ins;
        logic        e;
        logic [4:0]  c;
        logic        ordy;
        int          e_cnt;
        logic        e_ir, e_ov;
        logic [31:0] e_pc, e_ins;
        logic        e_exc;
        logic [4:0]  e_code;
    } vec_t;

    vec_t tbl[13];

    initial begin
        //            r  f  iv pc            ins           e  c     ordy cnt ir ov e_pc          e_ins         exc code
        tbl[0]  = '{0, 0, 0, 32'h0,        32'h0,        0, 5'h0, 0,   0,  1, 0, 32'h0,        32'h0,        0, 5'h0};
        tbl[1]  = '{1, 0, 1, 32'hbfc00000, 32'h24010001, 0, 5'h0, 0,   1,  1, 1, 32'hbfc00000, 32'h24010001, 0, 5'h0};
        tbl[2]  = '{1, 0, 1, 32'hbfc00004, 32'h00000002, 0, 5'h0, 0,   2,  1, 1, 32'hbfc00000, 32'h24010001, 0, 5'h0};
        tbl[3]  = '{1, 0, 1, 32'hbfc00008, 32'h00000003, 0, 5'h0, 0,   3,  1, 1, 32'hbfc00000, 32'h24010001, 0, 5'h0};
        tbl[4]  = '{1, 0, 1, 32'hbfc0000c, 32'h00000004, 0, 5'h0, 0,   4,  0, 1, 32'hbfc00000, 32'h24010001, 0, 5'h0};
        tbl[5]  = '{1, 0, 1, 32'hbfc00010, 32'h00000005, 0, 5'h0, 0,   4,  0, 1, 32'hbfc00000, 32'h24010001, 0, 5'h0};
        tbl[6]  = '{1, 0, 1, 32'hbfc00014, 32'h00000006, 0, 5'h0, 1,   3,  1, 1, 32'hbfc00004, 32'h00000002, 0, 5'h0};
        tbl[7]  = '{1, 0, 0, 32'h0,        32'h0,        0, 5'h0, 1,   2,  1, 1, 32'hbfc00008, 32'h00000003, 0, 5'h0};
        tbl[8]  = '{1, 0, 0, 32'h0,        32'h0,        0, 5'h0, 1,   1,  1, 1, 32'hbfc0000c, 32'h00000004, 0, 5'h0};
        tbl[9]  = '{1, 0, 0, 32'h0,        32'h0,        0, 5'h0, 1,   0,  1, 0, 32'h0,        32'h0,        0, 5'h0};
        tbl[10] = '{1, 0, 0, 32'h0,        32'h0,        0, 5'h0, 1,   0,  1, 0, 32'h0,        32'h0,        0, 5'h0};
        tbl[11] = '{1, 0, 1, 32'h00000200, 32'h0,        1, 5'h4, 1,   1,  1, 1, 32'h00000200, 32'h0,        1, 5'h4};
        tbl[12] = '{1, 0, 0, 32'h0,        32'h0,        0, 5'h0, 0,   1,  1, 1, 32'h00000200, 32'h0,        1, 5'h4};

        // Directed table: reset, first push, fill, overflow drop, full with
        // out_ready, drain in order, pop on empty, exception entry.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].e, tbl[i].c, tbl[i].ordy);
            check($sformatf("tbl%0d count", i),     32'(count),         32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d in_ready", i),  32'(in_ready),      32'(tbl[i].e_ir));
            check($sformatf("tbl%0d out_valid", i), 32'(out_valid),     32'(tbl[i].e_ov));
            check($sformatf("tbl%0d out_pc", i),    out_pc,             tbl[i].e_pc);
            check($sformatf("tbl%0d out_instr", i), out_instr,          tbl[i].e_ins);
            check($sformatf("tbl%0d out_exc", i),   32'(out_exception), 32'(tbl[i].e_exc));
            check($sformatf("tbl%0d out_code", i),  32'(out_exccode),   32'(tbl[i].e_code));
        end

        // Reset mid-operation with two entries queued.
        step(1, 0, 1, 32'h00000300, 32'h33, 0, 5'h0, 0);
        check("pre_rst count", 32'(count), 32'd2);
        step(0, 0, 1, 32'h00000304, 32'h34, 0, 5'h0, 1);
        check("rst count",     32'(count),     32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_instr", out_instr,      32'h0);

        // Flush with count=3 together with in_valid and out_ready.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 0, 5'h0, 0);
        check("pre_flush count", 32'(count), 32'd3);
        step(1, 1, 1, 32'h00000500, 32'h50, 1, 5'h7, 1);
        check("flush count",     32'(count),     32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_instr", out_instr,      32'h0);
        step(1, 0, 0, 32'h0, 32'h0, 0, 5'h0, 0);
        check_model("post_flush");

        // Steady push+pop at count=2 for 20 cycles; pointers wrap repeatedly.
        step(1, 0, 1, 32'h1000, 32'h1000, 0, 5'h0, 0);
        step(1, 0, 1, 32'h1004, 32'h1001, 0, 5'h0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 32'h1008 + 32'(4 * i), 32'h1002 + 32'(i), 0, 5'(i), 1);
            check($sformatf("stream%0d count", i), 32'(count), 32'd2);
            check($sformatf("stream%0d out_pc", i), out_pc, 32'h1004 + 32'(4 * i));
            check_model($sformatf("stream%0d", i));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(31) == 0),
                 ($urandom_range(9) < 7), $urandom, $urandom,
                 1'($urandom_range(1)), 5'($urandom_range(31)),
                 ($urandom_range(9) < 6));
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
